// File: rtl/dcache_core_tag_ctrl_if.sv
// Request/response and tag-RAM signal bundle for the dcache tag controller.
// The slave side is the controller; the master side is pipeline, refill and RAM.
interface dcache_core_tag_ctrl_if #(
    parameter int TAG_W = 19,
    parameter int IDX_W = 8
);
    logic             lookup_valid_i;
    logic [IDX_W-1:0] lookup_idx_i;
    logic [TAG_W-1:0] lookup_tag_i;
    logic             lookup_ready_o;
    logic             resp_valid_o;
    logic             resp_hit_o;
    logic             resp_dirty_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             fill_req_i;
    logic [IDX_W-1:0] fill_idx_i;
    logic [TAG_W-1:0] fill_tag_i;
    logic             fill_dirty_i;
    logic             fill_ack_o;
    logic             inval_req_i;
    logic [IDX_W-1:0] inval_idx_i;
    logic             inval_ack_o;
    logic             flush_req_i;
    logic             flush_ack_o;
    logic             busy_o;
    logic [IDX_W-1:0] tag_rd_addr_o;
    logic [TAG_W+1:0] tag_rd_data_i;
    logic [IDX_W-1:0] tag_wr_addr_o;
    logic [TAG_W+1:0] tag_wr_data_o;
    logic             tag_wr_o;

    modport master (
        output lookup_valid_i, lookup_idx_i, lookup_tag_i,
        output fill_req_i, fill_idx_i, fill_tag_i, fill_dirty_i,
        output inval_req_i, inval_idx_i, flush_req_i, tag_rd_data_i,
        input  lookup_ready_o, resp_valid_o, resp_hit_o, resp_dirty_o,
        input  resp_tag_o, fill_ack_o, inval_ack_o, flush_ack_o, busy_o,
        input  tag_rd_addr_o, tag_wr_addr_o, tag_wr_data_o, tag_wr_o
    );

    modport slave (
        input  lookup_valid_i, lookup_idx_i, lookup_tag_i,
        input  fill_req_i, fill_idx_i, fill_tag_i, fill_dirty_i,
        input  inval_req_i, inval_idx_i, flush_req_i, tag_rd_data_i,
        output lookup_ready_o, resp_valid_o, resp_hit_o, resp_dirty_o,
        output resp_tag_o, fill_ack_o, inval_ack_o, flush_ack_o, busy_o,
        output tag_rd_addr_o, tag_wr_addr_o, tag_wr_data_o, tag_wr_o
    );
endinterface

// File: rtl/dcache_core_tag_ctrl.sv
// Dcache tag RAM controller: invalidation sweeps, fill/inval write
// arbitration and single-cycle lookups with read-during-write forwarding.
module dcache_core_tag_ctrl #(
    parameter int TAG_W = 19,
    parameter int IDX_W = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    dcache_core_tag_ctrl_if.slave bus
);
    localparam int W = TAG_W + 2;

    typedef enum logic [1:0] {S_RESET, S_SWEEP, S_IDLE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] cnt;
    logic             sweep_flush;
    logic             cnt_last;

    logic             wr;
    logic [IDX_W-1:0] wr_addr;
    logic [W-1:0]     wr_data;
    logic             fill_ack;
    logic             inval_ack;
    logic             flush_ack;
    logic             ready;
    logic             busy;
    logic             accept;

    logic             resp_vld;
    logic [TAG_W-1:0] cmp_tag;
    logic             fwd_hit;
    logic [W-1:0]     fwd_word;
    logic [W-1:0]     word;

    assign cnt_last = (cnt == '1);
    assign accept   = bus.lookup_valid_i & ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_RESET;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RESET: state_nxt = S_SWEEP;
            S_SWEEP: if (cnt_last) state_nxt = S_IDLE;
            S_IDLE:  if (bus.flush_req_i) state_nxt = S_SWEEP;
            default: state_nxt = S_RESET;
        endcase
    end

    // Sweep owns the write port; fill beats inval otherwise.
    always_comb begin
        wr        = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        fill_ack  = 1'b0;
        inval_ack = 1'b0;
        flush_ack = 1'b0;
        ready     = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_SWEEP: begin
                wr        = 1'b1;
                wr_addr   = cnt;
                flush_ack = cnt_last & sweep_flush;
            end
            S_IDLE: begin
                busy  = 1'b0;
                ready = ~bus.flush_req_i;
                if (bus.fill_req_i) begin
                    wr       = 1'b1;
                    wr_addr  = bus.fill_idx_i;
                    wr_data  = {1'b1, bus.fill_dirty_i, bus.fill_tag_i};
                    fill_ack = 1'b1;
                end else if (bus.inval_req_i) begin
                    wr        = 1'b1;
                    wr_addr   = bus.inval_idx_i;
                    inval_ack = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= '0;
            sweep_flush <= 1'b0;
        end else if (state == S_SWEEP) begin
            cnt <= cnt + 1'b1;
        end else if (state == S_IDLE && bus.flush_req_i) begin
            cnt         <= '0;
            sweep_flush <= 1'b1;
        end else if (state == S_RESET) begin
            cnt         <= '0;
            sweep_flush <= 1'b0;
        end
    end

    // The RAM returns stale data on a same-address write; keep the new word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_vld <= 1'b0;
            cmp_tag  <= '0;
            fwd_hit  <= 1'b0;
            fwd_word <= '0;
        end else begin
            resp_vld <= accept;
            if (accept) begin
                cmp_tag  <= bus.lookup_tag_i;
                fwd_hit  <= wr && (wr_addr == bus.lookup_idx_i);
                fwd_word <= wr_data;
            end
        end
    end

    assign word = fwd_hit ? fwd_word : bus.tag_rd_data_i;

    assign bus.resp_valid_o   = resp_vld;
    assign bus.resp_hit_o     = resp_vld & word[W-1]
                                & (word[TAG_W-1:0] == cmp_tag);
    assign bus.resp_dirty_o   = resp_vld & word[TAG_W];
    assign bus.resp_tag_o     = resp_vld ? word[TAG_W-1:0] : '0;
    assign bus.lookup_ready_o = ready;
    assign bus.fill_ack_o     = fill_ack;
    assign bus.inval_ack_o    = inval_ack;
    assign bus.flush_ack_o    = flush_ack;
    assign bus.busy_o         = busy;
    assign bus.tag_rd_addr_o  = bus.lookup_idx_i;
    assign bus.tag_wr_addr_o  = wr_addr;
    assign bus.tag_wr_data_o  = wr_data;
    assign bus.tag_wr_o       = wr;
endmodule

// File: tb/tb_dcache_core_tag_ctrl.sv
// Bench for dcache_core_tag_ctrl: behavioural tag RAM plus a line-array
// reference model updated from the arbitration and sweep rules.
module tb_dcache_core_tag_ctrl;
    localparam int TAG_W = 19;
    localparam int IDX_W = 8;
    localparam int N     = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dcache_core_tag_ctrl_if #(.TAG_W(TAG_W), .IDX_W(IDX_W)) bus ();

    dcache_core_tag_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [20:0] ram [N];
    logic [20:0] model [N];

    always @(posedge clk) begin
        bus.tag_rd_data_i <= ram[bus.tag_rd_addr_o];
        if (bus.tag_wr_o) ram[bus.tag_wr_addr_o] <= bus.tag_wr_data_o;
    end

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.lookup_valid_i = 1'b0;
        bus.lookup_idx_i   = '0;
        bus.lookup_tag_i   = '0;
        bus.fill_req_i     = 1'b0;
        bus.fill_idx_i     = '0;
        bus.fill_tag_i     = '0;
        bus.fill_dirty_i   = 1'b0;
        bus.inval_req_i    = 1'b0;
        bus.inval_idx_i    = '0;
        bus.flush_req_i    = 1'b0;
    endtask

    task automatic sweep_after_reset(input string tag);
        int first_rdy = -1;
        int bad = 0;
        int acks = 0;
        rst = 1'b1;
        idle_in();
        cycle();
        cycle();
        chk({tag, "_rst_busy"}, 32'(bus.busy_o), 1);
        chk({tag, "_rst_ready"}, 32'(bus.lookup_ready_o), 0);
        chk({tag, "_rst_resp"}, {bus.resp_valid_o, bus.resp_hit_o,
            bus.resp_dirty_o, bus.resp_tag_o}, 0);
        chk({tag, "_rst_acks"}, {bus.fill_ack_o, bus.inval_ack_o,
            bus.flush_ack_o, bus.tag_wr_o}, 0);
        rst = 1'b0;
        #1;
        if (bus.tag_wr_o !== 1'b0) bad++;
        for (int k = 1; k <= 260; k++) begin
            cycle();
            if (k <= N) begin
                if (!(bus.tag_wr_o === 1'b1 && bus.busy_o === 1'b1 &&
                      bus.tag_wr_addr_o === 8'(k - 1) &&
                      bus.tag_wr_data_o === 21'd0)) bad++;
            end
            if (bus.flush_ack_o !== 1'b0) acks++;
            if (bus.lookup_ready_o === 1'b1 && first_rdy < 0) first_rdy = k;
        end
        chk({tag, "_sweep_writes"}, bad, 0);
        chk({tag, "_sweep_no_flush_ack"}, acks, 0);
        chk({tag, "_first_ready_cycle"}, first_rdy, 257);
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    // One IDLE cycle of requests, then the response check in the next cycle.
    task automatic op(input bit lv, input logic [7:0] li,
                      input logic [18:0] lt, input bit fr,
                      input logic [7:0] fi, input logic [18:0] ft,
                      input bit fd, input bit ir, input logic [7:0] ii);
        logic [20:0] w;
        bus.lookup_valid_i = lv;
        bus.lookup_idx_i   = li;
        bus.lookup_tag_i   = lt;
        bus.fill_req_i     = fr;
        bus.fill_idx_i     = fi;
        bus.fill_tag_i     = ft;
        bus.fill_dirty_i   = fd;
        bus.inval_req_i    = ir;
        bus.inval_idx_i    = ii;
        #1;
        chk("fill_ack", 32'(bus.fill_ack_o), 32'(fr));
        chk("inval_ack", 32'(bus.inval_ack_o), 32'(ir && !fr));
        chk("lookup_ready", 32'(bus.lookup_ready_o), 1);
        if (fr) model[fi] = {1'b1, fd, ft};
        else if (ir) model[ii] = '0;
        cycle();
        idle_in();
        #1;
        chk("resp_valid", 32'(bus.resp_valid_o), 32'(lv));
        if (lv) begin
            w = model[li];
            chk("resp_hit", 32'(bus.resp_hit_o), 32'(w[20] && w[18:0] == lt));
            chk("resp_dirty", 32'(bus.resp_dirty_o), 32'(w[19]));
            chk("resp_tag", 32'(bus.resp_tag_o), 32'(w[18:0]));
        end
    endtask

    initial begin
        int busy_cnt, fack_cnt, fack_at, fill_early, fill_late;
        logic [7:0] idx;
        logic [18:0] t;
        idle_in();
        bus.tag_rd_data_i = '0;
        sweep_after_reset("por");

        op(0, 0, 0, 1, 8'h12, 19'h1ABCD, 1, 0, 0);
        op(1, 8'h12, 19'h1ABCD, 0, 0, 0, 0, 0, 0);
        op(1, 8'h12, 19'h00001, 0, 0, 0, 0, 0, 0);
        op(1, 8'h40, 19'h7, 1, 8'h40, 19'h7, 0, 0, 0);
        op(1, 8'h40, 19'h7, 0, 0, 0, 0, 1, 8'h40);
        op(0, 0, 0, 1, 8'h05, 19'h5, 0, 0, 0);
        op(0, 0, 0, 1, 8'h03, 19'h3, 0, 1, 8'h05);
        op(0, 0, 0, 0, 0, 0, 0, 1, 8'h05);
        op(1, 8'h03, 19'h3, 0, 0, 0, 0, 0, 0);
        op(1, 8'h05, 19'h5, 0, 0, 0, 0, 0, 0);

        // A write in the response cycle must not alter that response.
        bus.lookup_valid_i = 1'b1;
        bus.lookup_idx_i   = 8'h03;
        bus.lookup_tag_i   = 19'h3;
        cycle();
        idle_in();
        bus.inval_req_i = 1'b1;
        bus.inval_idx_i = 8'h03;
        #1;
        chk("n1_inval_ack", 32'(bus.inval_ack_o), 1);
        chk("n1_resp_hit", 32'(bus.resp_hit_o), 32'(model[3][20]));
        model[3] = '0;
        cycle();
        idle_in();
        op(1, 8'h03, 19'h3, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            idx = 8'($urandom_range(0, 15));
            t = ($urandom_range(0, 1) != 0) ? model[idx][18:0]
                                            : 19'($urandom_range(0, 3));
            op(1'($urandom_range(0, 1)), idx, t,
               1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 15)),
               19'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 2) == 0), 8'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10; i++)
            op(0, 0, 0, 1, 8'(8'h80 + 3 * i), 19'(8'h20 + i), 1, 0, 0);
        bus.flush_req_i = 1'b1;
        #1;
        chk("flush_req_ready", 32'(bus.lookup_ready_o), 0);
        chk("flush_req_busy", 32'(bus.busy_o), 0);
        busy_cnt = 0; fack_cnt = 0; fack_at = -1;
        fill_early = 0; fill_late = 0;
        for (int j = 1; j <= 257; j++) begin
            cycle();
            if (j == 50) begin
                bus.fill_req_i   = 1'b1;
                bus.fill_idx_i   = 8'h33;
                bus.fill_tag_i   = 19'h55;
                bus.fill_dirty_i = 1'b0;
            end
            if (j == 257) bus.flush_req_i = 1'b0;
            #1;
            if (bus.busy_o === 1'b1) busy_cnt++;
            if (bus.flush_ack_o === 1'b1) begin
                fack_cnt++;
                fack_at = j;
            end
            if (j < 257 && bus.fill_ack_o !== 1'b0) fill_early++;
            if (j == 257) fill_late = int'(bus.fill_ack_o);
        end
        for (int i = 0; i < N; i++) model[i] = '0;
        model[8'h33] = {1'b1, 1'b0, 19'h55};
        cycle();
        idle_in();
        chk("flush_busy_cycles", busy_cnt, 256);
        chk("flush_ack_count", fack_cnt, 1);
        chk("flush_ack_cycle", fack_at, 256);
        chk("fill_during_sweep", fill_early, 0);
        chk("fill_after_sweep", fill_late, 1);
        for (int i = 0; i < 10; i++)
            op(1, 8'(8'h80 + 3 * i), 19'(8'h20 + i), 0, 0, 0, 0, 0, 0);
        op(1, 8'h33, 19'h55, 0, 0, 0, 0, 0, 0);

        bus.flush_req_i = 1'b1;
        fack_cnt = 0;
        for (int j = 1; j <= 101; j++) begin
            cycle();
            if (bus.flush_ack_o !== 1'b0) fack_cnt++;
        end
        bus.flush_req_i = 1'b0;
        sweep_after_reset("midrst");
        chk("midrst_no_flush_ack", fack_cnt, 0);
        op(1, 8'h33, 19'h55, 0, 0, 0, 0, 0, 0);
        op(1, 8'h12, 19'h1ABCD, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dcache_core_tag_ctrl.md
Name: dcache_core_tag_ctrl

Overview:
Controller and arbiter for the data-cache tag RAM (256 x 21, one synchronous read port, one write port, 1-cycle read latency).
- Sequences the post-reset and on-demand invalidation sweeps.
- Arbitrates line-fill and single-line-invalidate writes.
- Issues lookups and returns the hit/dirty result one cycle later, forwarding same-cycle writes.
- Sits between the dcache core pipeline/refill logic and the tag RAM instance.

Parameters:
- TAG_W, 19, tag field width; the RAM word is TAG_W+2.
- IDX_W, 8, line-index width; the sweep covers 2^IDX_W entries.

Ports:
- clk_i  in  1  clock (also drives the tag RAM clk0/clk1)
- rst_i  in  1  synchronous, active-high reset
- lookup_valid_i  in  1  lookup request
- lookup_idx_i  in  8  line index
- lookup_tag_i  in  19  compare tag
- lookup_ready_o  out  1  lookup accepted when high
- resp_valid_o  out  1  lookup result valid
- resp_hit_o  out  1  entry valid and tag match
- resp_dirty_o  out  1  entry dirty bit
- resp_tag_o  out  19  stored tag, for victim writeback address
- fill_req_i  in  1  write valid line; held until ack
- fill_idx_i  in  8  fill index
- fill_tag_i  in  19  fill tag
- fill_dirty_i  in  1  dirty bit to write
- fill_ack_o  out  1  fill write performed this cycle
- inval_req_i  in  1  invalidate one line; held until ack
- inval_idx_i  in  8  index to invalidate
- inval_ack_o  out  1  invalidate performed this cycle
- flush_req_i  in  1  invalidate all lines; held until ack
- flush_ack_o  out  1  1-cycle pulse on sweep completion
- busy_o  out  1  sweep in progress
- tag_rd_addr_o  out  8  to RAM addr0
- tag_rd_data_i  in  21  from RAM data0
- tag_wr_addr_o  out  8  to RAM addr1
- tag_wr_data_o  out  21  to RAM data1
- tag_wr_o  out  1  to RAM wr1

Behaviour:
- RAM word format: [20] valid, [19] dirty, [18:0] tag.
- FSM states:
  - S_RESET: entered on rst_i. Clears the counter; busy_o=1.
  - S_SWEEP: writes 21'b0 to address cnt each cycle, then cnt++.
    - At cnt==255 the write completes. Go to S_IDLE.
    - If the sweep was flush-initiated, pulse flush_ack_o in that same cycle.
    - A post-reset sweep never pulses flush_ack_o.
  - S_IDLE: normal operation. flush_req_i=1 -> S_SWEEP with cnt=0; the first sweep write happens in the next cycle.
- Post-reset sweep: exactly 256 write cycles. lookup_ready_o first rises 257 cycles after rst_i falls (1 S_RESET cycle + 256 sweep cycles).
- Reset values:
  - busy_o=1.
  - lookup_ready_o=0, resp_valid_o=0, resp_hit_o=0, resp_dirty_o=0, resp_tag_o=0.
  - fill_ack_o=0, inval_ack_o=0, flush_ack_o=0, tag_wr_o=0.
  - Internal counter=0.
- Reset mid-sweep or mid-operation: abort, restart the full post-reset sweep, drop any pending response.
- lookup_ready_o=1 only in S_IDLE and not transitioning to S_SWEEP this cycle.
- Lookup handshake:
  - Accepted when lookup_valid_i & lookup_ready_o. tag_rd_addr_o=lookup_idx_i in that cycle (N).
  - resp_valid_o=1 in cycle N+1 only; results are combinational from tag_rd_data_i plus a registered compare tag.
  - resp_hit_o = valid & (stored tag == compare tag).
- Write arbitration (IDLE only, at most one write per cycle):
  - Priority: fill > inval.
  - ack is combinational in the write cycle; the losing requester waits.
  - fill writes {1, fill_dirty_i, fill_tag_i}. inval writes 21'b0.
- Sweep has absolute priority: fill/inval acks stay low during S_SWEEP and are honoured after return to S_IDLE.
- Read-during-write forwarding:
  - The RAM returns old data when read and write hit the same address in the same cycle.
  - If a write in cycle N targets the accepted lookup index, register the write data and use it in place of tag_rd_data_i for the N+1 response.
- Writes in cycle N+1 do not affect the N+1 response; the pipeline sees them on its next lookup.
- flush_req_i and fill_req_i both asserted in IDLE: the fill is performed and acked this cycle, and the sweep starts the next cycle. The flush still wipes the filled line.
- flush_req_i must be held until flush_ack_o. After the ack, deassert it the following cycle; if still high it starts another sweep.
- tag_rd_addr_o = lookup_idx_i whenever no sweep is active (don't care otherwise).

Test Plan:
- Reset release -> tag_wr_o high for 256 consecutive cycles, addrs 0..255, data 0; lookup_ready_o=1 on cycle 257; no flush_ack_o.
- Fill idx 0x12 tag 0x1ABCD dirty=1, then lookup idx 0x12 tag 0x1ABCD -> resp_hit_o=1, resp_dirty_o=1; same lookup with tag 0x00001 -> hit=0, resp_tag_o=0x1ABCD.
- Same-cycle fill idx 0x40 tag 0x7 and lookup idx 0x40 tag 0x7 -> next-cycle resp_hit_o=1 via forwarding; then inval 0x40 plus same-cycle lookup -> hit=0.
- fill_req_i and inval_req_i together (idx 3 and 5) -> fill_ack_o first cycle, inval_ack_o second cycle; final lookups: idx 3 hit, idx 5 miss.
- Fill 10 lines, flush_req_i=1 -> busy_o high 256 cycles, flush_ack_o single pulse on last write, all 10 lookups miss afterwards; fill_req_i raised mid-sweep acked only after.
- rst_i asserted at sweep count 100 of a flush -> no flush_ack_o, fresh 256-cycle sweep from addr 0.
